// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver: assembles LSB-first WIDTH-bit words from a valid-qualified
// bit stream and buffers them in a DEPTH-entry FIFO behind a valid/ready port.
module serial_parallel #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             parallel_vld_o,
  input  logic             parallel_rdy_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overflow_o
);

  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             last_bit, full, pop, push_ok;
  logic [WIDTH-1:0] word;

  assign last_bit = valid_i && (cnt_q == CW'(WIDTH - 1));
  assign word     = {serial_i, shift_q[WIDTH-1:1]};
  assign full     = (count_q == CNTW'(DEPTH));
  assign pop      = parallel_vld_o && parallel_rdy_i;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept the word.
  assign push_ok  = last_bit && (!full || pop);

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    overflow_d  = last_bit && full && !pop;

    if (valid_i) begin
      shift_d = word;
      cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d       = '0;
      frame_err_d = 1'b1;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (push_ok) mem_q[wr_ptr_q] <= word;
    end
  end

  assign parallel_o     = mem_q[rd_ptr_q];
  assign parallel_vld_o = (count_q != '0);
  assign busy_o         = (cnt_q != '0);
  assign frame_err_o    = frame_err_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_serial_parallel.sv
// Directed bench for serial_parallel: word assembly, framing errors, FIFO overflow and reset.
module tb_serial_parallel;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_i;
  logic       valid_i;
  logic [3:0] parallel_o;
  logic       parallel_vld_o;
  logic       parallel_rdy_i;
  logic       busy_o;
  logic       frame_err_o;
  logic       overflow_o;

  int nvec = 0;
  int nerr = 0;

  serial_parallel #(.WIDTH(4), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_i       (serial_i),
    .valid_i        (valid_i),
    .parallel_o     (parallel_o),
    .parallel_vld_o (parallel_vld_o),
    .parallel_rdy_i (parallel_rdy_i),
    .busy_o         (busy_o),
    .frame_err_o    (frame_err_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    valid_i  = 1'b1;
    serial_i = b;
    tick();
  endtask

  task automatic idle();
    valid_i  = 1'b0;
    serial_i = 1'b0;
    tick();
  endtask

  // Sends a word LSB first.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_par"},  parallel_o, 0);
    chk({tag, "_vld"},  parallel_vld_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ferr"}, frame_err_o, 0);
    chk({tag, "_ovf"},  overflow_o, 0);
  endtask

  initial begin
    reset = 1'b1; serial_i = 1'b0; valid_i = 1'b0; parallel_rdy_i = 1'b0;
    #2;
    chk_all_zero("rst");
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: bits 0,1,0,1 -> 4'hA
    chk("t1_busy0", busy_o, 0);
    send_bit(1'b0); chk("t1_busy_b1", busy_o, 1);
    send_bit(1'b1); chk("t1_busy_b2", busy_o, 1);
    send_bit(1'b0); chk("t1_busy_b3", busy_o, 1); chk("t1_vld_early", parallel_vld_o, 0);
    send_bit(1'b1);
    chk("t1_busy_done", busy_o, 0);
    chk("t1_vld", parallel_vld_o, 1);
    chk("t1_par", parallel_o, 4'hA);
    parallel_rdy_i = 1'b1;
    idle();
    chk("t1_pop_vld", parallel_vld_o, 0);
    chk("t1_ferr", frame_err_o, 0);

    // 2: 4'h3 then 4'hC back to back, rdy high
    send_bit(1'b1); chk("t2_vld1", parallel_vld_o, 0);
    send_bit(1'b1); chk("t2_vld2", parallel_vld_o, 0);
    send_bit(1'b0); chk("t2_vld3", parallel_vld_o, 0);
    send_bit(1'b0); chk("t2_vld4", parallel_vld_o, 1); chk("t2_par3", parallel_o, 4'h3);
    send_bit(1'b0); chk("t2_vld5", parallel_vld_o, 0); chk("t2_ferr5", frame_err_o, 0);
    send_bit(1'b0); chk("t2_vld6", parallel_vld_o, 0);
    send_bit(1'b1); chk("t2_vld7", parallel_vld_o, 0);
    send_bit(1'b1); chk("t2_vld8", parallel_vld_o, 1); chk("t2_parC", parallel_o, 4'hC);
    chk("t2_ferr8", frame_err_o, 0);
    chk("t2_ovf8", overflow_o, 0);
    idle();
    chk("t2_vld_end", parallel_vld_o, 0);

    // 3: truncated word 1,1 then a good 4'h5
    send_bit(1'b1); send_bit(1'b1);
    chk("t3_busy", busy_o, 1);
    chk("t3_ferr_pre", frame_err_o, 0);
    idle();
    chk("t3_ferr", frame_err_o, 1);
    chk("t3_busy_clr", busy_o, 0);
    chk("t3_vld_none", parallel_vld_o, 0);
    idle();
    chk("t3_ferr_once", frame_err_o, 0);
    send_word(4'h5);
    chk("t3_vld5", parallel_vld_o, 1);
    chk("t3_par5", parallel_o, 4'h5);
    chk("t3_ferr_after", frame_err_o, 0);
    idle();
    chk("t3_vld_end", parallel_vld_o, 0);

    // 4: rdy low, three words -> overflow on the third
    parallel_rdy_i = 1'b0;
    send_word(4'h1);
    chk("t4_vld1", parallel_vld_o, 1); chk("t4_par1", parallel_o, 4'h1);
    send_word(4'h2);
    chk("t4_par_hold", parallel_o, 4'h1); chk("t4_ovf2", overflow_o, 0);
    send_word(4'h3);
    chk("t4_ovf3", overflow_o, 1);
    chk("t4_par_kept", parallel_o, 4'h1);
    idle();
    chk("t4_ovf_once", overflow_o, 0);
    parallel_rdy_i = 1'b1;
    tick();
    chk("t4_pop1_vld", parallel_vld_o, 1);
    chk("t4_pop1_par", parallel_o, 4'h2);
    tick();
    chk("t4_empty", parallel_vld_o, 0);
    chk("t4_ovf_end", overflow_o, 0);

    // 5: FIFO full, pop in the cycle the third word completes
    parallel_rdy_i = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    parallel_rdy_i = 1'b1;
    send_bit(1'b0);
    chk("t5_ovf", overflow_o, 0);
    chk("t5_vld", parallel_vld_o, 1);
    chk("t5_par2", parallel_o, 4'h2);
    idle();
    chk("t5_ovf_next", overflow_o, 0);
    chk("t5_vld3", parallel_vld_o, 1);
    chk("t5_par3", parallel_o, 4'h3);
    idle();
    chk("t5_empty", parallel_vld_o, 0);

    // 6: async reset mid-word with one word buffered
    parallel_rdy_i = 1'b0;
    send_word(4'h7);
    send_bit(1'b1); send_bit(1'b0);
    chk("t6_busy_pre", busy_o, 1);
    chk("t6_vld_pre", parallel_vld_o, 1);
    chk("t6_par_pre", parallel_o, 4'h7);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("t6_async");
    valid_i = 1'b0;
    tick();
    chk_all_zero("t6_held");
    #2;
    reset = 1'b0;
    tick();
    chk("t6_ferr_post", frame_err_o, 0);
    chk("t6_busy_post", busy_o, 0);
    send_word(4'h9);
    chk("t6_vld9", parallel_vld_o, 1);
    chk("t6_par9", parallel_o, 4'h9);
    chk("t6_ferr9", frame_err_o, 0);
    parallel_rdy_i = 1'b1;
    idle();
    chk("t6_empty", parallel_vld_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
